// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Sequences each access for LAT cycles and generates the pipeline stall terms.
module mem_port_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        i_abort,
  input  logic        d_re,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic        hlt,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [15:0] i_rdata,
  output logic        i_valid,
  output logic [15:0] d_rdata,
  output logic        d_valid,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        squash_q, squash_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  logic        i_want_s;
  logic        d_want_s;
  logic        grant_i_s;
  logic        grant_d_s;
  logic        done_s;

  // Next-state: grant selection, latency countdown and squash tracking.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    squash_d     = squash_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    grant_i_s    = 1'b0;
    grant_d_s    = 1'b0;
    done_s       = 1'b0;
    i_want_s     = i_req & ~i_abort;
    d_want_s     = d_re | d_we;

    case (state_q)
      IDLE: begin
        if (!hlt) begin
          // D wins contention unless it had the previous grant.
          if (d_want_s && (!i_want_s || !last_grant_q)) begin
            grant_d_s = 1'b1;
          end else if (i_want_s) begin
            grant_i_s = 1'b1;
          end else begin
            grant_d_s = 1'b0;
          end
        end else begin
          grant_d_s = 1'b0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_q == 4'd0) begin
          done_s  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant_d_s) begin
      state_d      = BUSY_D;
      cnt_d        = CNT_LOAD;
      last_grant_d = 1'b1;
      squash_d     = 1'b0;
      addr_d       = d_addr;
      wdata_d      = d_wdata;
    end else if (grant_i_s) begin
      state_d      = BUSY_I;
      cnt_d        = CNT_LOAD;
      last_grant_d = 1'b0;
      squash_d     = 1'b0;
      addr_d       = i_addr;
    end else if ((state_q == BUSY_I) && i_abort) begin
      squash_d = 1'b1;
    end else begin
      squash_d = squash_q;
    end
  end

  // State register; reset discards any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b0;
      squash_q     <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      squash_q     <= squash_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Output decode; every output is held low while reset is asserted.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    i_rdata   = 16'h0000;
    i_valid   = 1'b0;
    d_rdata   = 16'h0000;
    d_valid   = 1'b0;
    stall_if  = 1'b0;
    stall_mem = 1'b0;

    if (rst_n) begin
      if (grant_d_s) begin
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_re    = d_re;
        mem_we    = d_we;
      end else if (grant_i_s) begin
        mem_addr  = i_addr;
        mem_wdata = wdata_q;
        mem_re    = 1'b1;
      end else begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end

      i_valid = done_s & (state_q == BUSY_I) & ~squash_q & ~i_abort;
      d_valid = done_s & (state_q == BUSY_D);

      if (i_valid) begin
        i_rdata = mem_rdata;
      end else begin
        i_rdata = 16'h0000;
      end

      if (d_valid) begin
        d_rdata = mem_rdata;
      end else begin
        d_rdata = 16'h0000;
      end

      stall_if  = i_req & ~i_valid & ~i_abort;
      stall_mem = (d_re | d_we) & ~d_valid;
    end else begin
      mem_addr = 16'h0000;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported, fixed-latency unified memory between the IF-stage instruction fetch and the MEM-stage load/store in the 5-stage pipeline. It sequences each access through a small FSM and latency counter, and returns read data with a one-cycle valid strobe. It also generates the per-stage stall signals that the pipeline ORs into its existing stall/halt terms. Instruction fetches can be squashed on a taken branch or jump.

## Interface
- LAT, 2, memory read latency in cycles (legal 1..15); all accesses occupy the port for LAT cycles
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  IF requests a fetch; held until i_valid or i_abort
- i_addr  in  16  fetch address (pc)
- i_abort  in  1  squash current/pending fetch (taken branch or jump)
- d_re  in  1  MEM-stage load request; held until d_valid
- d_we  in  1  MEM-stage store request; held until d_valid; d_re and d_we never both high
- d_addr  in  16  load/store address (alu result)
- d_wdata  in  16  store data
- hlt  in  1  halt: no new grants
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_re  out  1  one-cycle read strobe
- mem_we  out  1  one-cycle write strobe
- mem_rdata  in  16  memory read data, valid LAT cycles after mem_re
- i_rdata  out  16  fetched instruction (valid with i_valid)
- i_valid  out  1  one-cycle fetch completion
- d_rdata  out  16  load data (valid with d_valid)
- d_valid  out  1  one-cycle load/store completion
- stall_if  out  1  hold IF and IF/ID
- stall_mem  out  1  hold EX/MEM and all earlier stages

## Operation
- States: IDLE, BUSY_I, BUSY_D. There is a 4-bit counter cnt and a last_grant flag (0 = I, 1 = D).
- Grant in IDLE happens only when hlt=0. The grant drives mem_re/mem_we, mem_addr and mem_wdata combinationally in the same cycle.
  - A D request alone is granted to D.
  - An I request alone, with i_abort=0, is granted to I.
  - When both request: D wins if last_grant=0, I wins if last_grant=1.
  - On grant: state goes to BUSY_x, cnt=LAT-1, and last_grant is updated.
- In BUSY_x, mem_re and mem_we are 0, and mem_addr/mem_wdata hold the granted values.
  - cnt decrements each cycle.
  - When cnt==1 (or immediately after grant if LAT=1), the next cycle is the completion cycle.
  - In the completion cycle, x_valid=1 and x_rdata=mem_rdata combinationally. The state returns to IDLE at the following edge.
- Stores occupy the port for LAT cycles. d_valid pulses in the completion cycle. d_rdata is don't-care on a store.
- Abort: i_abort high at any point from the grant cycle through the completion cycle marks the fetch squashed.
  - A squashed fetch suppresses i_valid. The memory access still runs to completion.
  - i_abort in IDLE blocks an I grant in that cycle. A D grant is still allowed.
- stall_if = i_req & ~i_valid & ~i_abort.
- stall_mem = (d_re|d_we) & ~d_valid.
- hlt: an in-flight access completes normally. After that the block stays in IDLE with no strobes.
- Reset (asynchronous, any time, including mid-access):
  - state=IDLE, cnt=0, last_grant=0, squash flag=0.
  - The in-flight access is discarded.
  - All outputs are forced to 0 while rst_n=0.

## Timing
- Grant at cycle t. x_valid is high in cycle t+LAT. The earliest next grant is at cycle t+LAT+1.
- Throughput is one access per LAT+1 cycles.
- Under contention the requester that is not granted stalls until its own completion cycle.
- Every valid and strobe output is exactly one cycle wide.
- Address and data are sampled from the requester only in the grant cycle. Later changes are ignored.
- cnt never wraps. For LAT=1 it is loaded with 0, and completion occurs at t+1.

## Test plan
- **Lone fetch:** LAT=2, i_req with i_addr=0x0010 at cycle 0, mem_rdata=0xB123 at cycle 2.
  - mem_re=1 and mem_addr=0x0010 in cycle 0.
  - stall_if=1 in cycles 0–1.
  - i_valid=1 with i_rdata=0xB123 in cycle 2, stall_if=0 in cycle 2.
- **Contention after reset:** i_req plus d_re with d_addr=0x0040 at cycle 0.
  - D is granted in cycle 0, d_valid in cycle 2.
  - I is granted in cycle 3, i_valid in cycle 5.
  - stall_if is held high in cycles 0–4.
- **Alternation:** after the D access above completes, d_we with d_wdata=0x5555 and i_req are both pending.
  - I is granted first (last_grant=1).
  - The store issues next, with mem_we=1 and mem_wdata=0x5555.
- **Abort:** i_abort pulses in cycle 1 of a fetch granted at cycle 0.
  - i_valid stays 0 in cycle 2.
  - The state is IDLE in cycle 3, and a new i_addr=0x0020 issues with mem_re in cycle 3.
- **Halt:** hlt rises in cycle 1 of a D access.
  - d_valid occurs in cycle 2.
  - No mem_re or mem_we occurs for 10 more cycles, with i_req held high.
- **Reset mid-access:** rst_n falls in cycle 1.
  - All outputs are 0 immediately, and no d_valid occurs.
  - After release, a pending d_re is granted on the first cycle with rst_n=1.
